// File: rtl/retraso_vc_param_if.sv
// Bundle of virtual-channel data/empty flags and pipeline controls between the
// VC FIFOs (master side) and the retiming stage (slave side).
interface retraso_vc_param_if #(
  parameter int NUM_VC = 2,
  parameter int DATA_W = 6
);
  logic [NUM_VC*DATA_W-1:0] vc_data;
  logic [NUM_VC-1:0]        vc_empty;
  logic [NUM_VC-1:0]        pop_delay;
  logic                     stall;
  logic                     flush;
  logic [NUM_VC*DATA_W-1:0] vc_data_retrasado;
  logic [NUM_VC-1:0]        vc_empty_retrasado;
  logic [NUM_VC-1:0]        vc_drained;

  modport master (
    output vc_data, vc_empty, pop_delay, stall, flush,
    input  vc_data_retrasado, vc_empty_retrasado, vc_drained
  );

  modport slave (
    input  vc_data, vc_empty, pop_delay, stall, flush,
    output vc_data_retrasado, vc_empty_retrasado, vc_drained
  );
endinterface

// File: rtl/retraso_vc_param.sv
// DEPTH-stage retiming of NUM_VC data/empty channels with stall, flush and drain pulse.
// Optional feature macro: RETRASO_POP_GATE_EN (stage-0 capture gated by pop_delay).
module retraso_vc_param #(
  parameter int NUM_VC = 2,
  parameter int DATA_W = 6,
  parameter int DEPTH  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  retraso_vc_param_if.slave    bus
);

  if (DEPTH < 1) begin : g_depth_check
    $error("retraso_vc_param: DEPTH must be at least 1");
  end

  logic [NUM_VC*DATA_W-1:0] data_p  [DEPTH];
  logic [NUM_VC-1:0]        empty_p [DEPTH];
  logic [NUM_VC-1:0]        drained_q;
  logic [NUM_VC*DATA_W-1:0] data_in;
  logic [NUM_VC-1:0]        empty_in;
  logic [NUM_VC-1:0]        empty_last_nxt;

  // Stage-0 source: raw inputs, or a bubble for channels not popped this cycle
`ifdef RETRASO_POP_GATE_EN
  always_comb begin
    data_in  = '0;
    empty_in = '1;
    for (int i = 0; i < NUM_VC; i++) begin
      if (bus.pop_delay[i]) begin
        data_in[i*DATA_W +: DATA_W] = bus.vc_data[i*DATA_W +: DATA_W];
        empty_in[i]                 = bus.vc_empty[i];
      end
    end
  end
`else
  logic unused_pop_delay;
  assign unused_pop_delay = ^bus.pop_delay;
  assign data_in          = bus.vc_data;
  assign empty_in         = bus.vc_empty;
`endif

  // Value the last stage's empty flag takes on the next shift edge
  if (DEPTH == 1) begin : g_last_from_in
    assign empty_last_nxt = empty_in;
  end else begin : g_last_from_prev
    assign empty_last_nxt = empty_p[DEPTH-2];
  end

  // Stages 0..DEPTH-1 plus the drain-pulse register
  always_ff @(posedge clk) begin
    if (reset || bus.flush) begin
      for (int s = 0; s < DEPTH; s++) begin
        data_p[s]  <= '0;
        empty_p[s] <= '1;
      end
      drained_q <= '0;
    end else if (!bus.stall) begin
      data_p[0]  <= data_in;
      empty_p[0] <= empty_in;
      for (int s = 1; s < DEPTH; s++) begin
        data_p[s]  <= data_p[s-1];
        empty_p[s] <= empty_p[s-1];
      end
      drained_q <= empty_last_nxt & ~empty_p[DEPTH-1];
    end
  end

  assign bus.vc_data_retrasado  = data_p[DEPTH-1];
  assign bus.vc_empty_retrasado = empty_p[DEPTH-1];
  assign bus.vc_drained         = drained_q;

endmodule
